// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if -- operand/result bundle between the EX stage and div_unit.
//
//   a          [31:0]  dividend (rs value)
//   b          [31:0]  divisor (rt value)
//   signed_div         1 = DIV (two's complement), 0 = DIVU
//   start              request a new division (honoured only when idle)
//   annul              flush/exception cancel of the in-flight division
//   result     [63:0]  {remainder -> HI, quotient -> LO}
//   ready              one-cycle pulse, result newly written that cycle
//   stall_req          combinational stall request to the EX stage
//
// master: pipeline side (drives operands/controls)
// slave : divider side (drives result/status)
// ---------------------------------------------------------------------------
interface div_unit_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        signed_div;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stall_req;

   modport master (
      output a, b, signed_div, start, annul,
      input  result, ready, stall_req
   );

   modport slave (
      input  a, b, signed_div, start, annul,
      output result, ready, stall_req
   );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit DIV/DIVU unit for the EX stage.
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset (priority over annul and start)
//   bus  div_unit_if.slave: a, b, signed_div, start, annul in;
//        result {rem, quo}, ready pulse, stall_req out
//
// Behaviour:
//   IDLE --start,b!=0--> DIV_ON (32 restoring iterations) --> DIV_END
//   IDLE --start,b==0--> DIV_ZERO --> DIV_END (result = 0)
//   DIV_END asserts ready for one cycle and returns to IDLE.
//   Latency from the start edge: 33 cycles (b!=0) or 2 cycles (b==0).
//   annul in DIV_ON/DIV_ZERO aborts with no ready and result untouched.
// ---------------------------------------------------------------------------
module div_unit (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_ON   = 2'd2,
      DIV_END  = 2'd3
   } state_t;

   state_t      state;
   logic [4:0]  cnt;        // iteration index within DIV_ON
   logic [31:0] dvs;        // divisor magnitude
   logic [31:0] quo;        // dividend shifting out / quotient shifting in
   logic [32:0] rem;        // partial remainder
   logic        neg_a;      // dividend negative (signed op only)
   logic        neg_b;      // divisor negative (signed op only)
   logic        sgn;        // latched signed_div
   logic [63:0] result_r;
   logic        ready_r;

   // operand magnitudes at the start cycle
   logic        a_neg_in;
   logic        b_neg_in;
   logic [31:0] a_abs;
   logic [31:0] b_abs;

   // one restoring iteration
   logic [33:0] rem_sh;
   logic [33:0] diff;
   logic        borrow;
   logic [32:0] rem_nx;
   logic [31:0] quo_nx;

   // sign-corrected final values
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   always_comb begin
      a_neg_in = bus.signed_div & bus.a[31];
      b_neg_in = bus.signed_div & bus.b[31];
      a_abs    = a_neg_in ? (32'd0 - bus.a) : bus.a;
      b_abs    = b_neg_in ? (32'd0 - bus.b) : bus.b;
   end

   // Shift the next dividend bit into the remainder and try to subtract the
   // divisor; a borrow means the trial failed and the shifted value is kept.
   always_comb begin
      rem_sh = {rem, quo[31]};
      diff   = rem_sh - {2'b00, dvs};
      borrow = diff[33];
      rem_nx = borrow ? rem_sh[32:0] : diff[32:0];
      quo_nx = {quo[30:0], ~borrow};
   end

   // Quotient takes the XOR of the operand signs; remainder follows the
   // dividend. 0x80000000 / -1 wraps back to 0x80000000 naturally.
   always_comb begin
      quo_fix = (sgn & (neg_a ^ neg_b)) ? (32'd0 - quo_nx) : quo_nx;
      rem_fix = (sgn & neg_a) ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         dvs      <= '0;
         quo      <= '0;
         rem      <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         sgn      <= 1'b0;
         result_r <= '0;
         ready_r  <= 1'b0;
      end else begin
         ready_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.annul) begin
                  if (bus.b == 32'd0) begin
                     state <= DIV_ZERO;
                  end else begin
                     dvs   <= bus.signed_div ? b_abs : bus.b;
                     quo   <= bus.signed_div ? a_abs : bus.a;
                     rem   <= '0;
                     neg_a <= a_neg_in;
                     neg_b <= b_neg_in;
                     sgn   <= bus.signed_div;
                     cnt   <= '0;
                     state <= DIV_ON;
                  end
               end
            end

            DIV_ZERO: begin
               if (bus.annul) begin
                  state <= IDLE;
               end else begin
                  result_r <= '0;
                  ready_r  <= 1'b1;
                  state    <= DIV_END;
               end
            end

            DIV_ON: begin
               if (bus.annul) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + 5'd1;
                  // Last iteration: fold sign correction into the write so
                  // result and ready appear together on entry to DIV_END.
                  if (cnt == 5'd31) begin
                     result_r <= {rem_fix, quo_fix};
                     ready_r  <= 1'b1;
                     state    <= DIV_END;
                  end
               end
            end

            DIV_END: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.result    = result_r;
   assign bus.ready     = ready_r;
   assign bus.stall_req = ~rst & (((state == IDLE) & bus.start & ~bus.annul) |
                                  (state == DIV_ZERO) |
                                  (state == DIV_ON));

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- table-driven directed bench for div_unit, plus hand-written
// sequences for annul, reset and start-priority corner cases.
// Inputs change #1 after posedge (or on negedge for the start cycle);
// outputs are sampled #1 after negedge.
// ---------------------------------------------------------------------------
module tb_div_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      bit          noise;
      logic [63:0] exp;
   } vec_t;

   vec_t vt[13];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Issue one division and watch it to completion. Operands are scrambled
   // every busy cycle; with noise set, start is also held high while busy.
   task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input bit noise, output logic [63:0] res);
      int explat;
      int first;
      int pulses;
      int stall_bad;
      explat    = (bv == 32'd0) ? 2 : 33;
      first     = 0;
      pulses    = 0;
      stall_bad = 0;
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.signed_div = sv; bus.start = 1'b1; bus.annul = 1'b0;
      #1;
      if (bus.stall_req !== 1'b1) stall_bad++;
      for (int i = 1; i <= explat + 2; i++) begin
         @(posedge clk); #1;
         bus.a          = $urandom;
         bus.b          = $urandom;
         bus.signed_div = ~bus.signed_div;
         bus.start      = (noise && i < explat) ? 1'b1 : 1'b0;
         @(negedge clk); #1;
         if (bus.ready === 1'b1) begin
            if (first == 0) first = i;
            pulses++;
         end
         if (bus.stall_req !== ((i < explat) ? 1'b1 : 1'b0)) stall_bad++;
      end
      res = bus.result;
      check($sformatf("%s_ready_cycle", tag), 64'(first), 64'(explat));
      check($sformatf("%s_ready_pulses", tag), 64'(pulses), 64'd1);
      check($sformatf("%s_stall_pattern", tag), 64'(stall_bad), 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      logic [63:0] prev;
      int          rdy_seen;
      int          stall_seen;

      //            a             b             s     noise  {rem, quo}
      vt[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, {32'd2,        32'd14}};
      vt[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD}};
      vt[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, {32'h00000001, 32'hFFFFFFFD}};
      vt[3]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, {32'h0,        32'hFFFFFFFF}};
      vt[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, {32'h0,        32'h80000000}};
      vt[5]  = '{32'h12345678, 32'd0,        1'b0, 1'b0, 64'h0};
      vt[6]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b0, {32'hFFFFFFFF, 32'd3}};
      vt[7]  = '{32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, {32'd1,        32'h7FFFFFFC}};
      vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, {32'd1,        32'd1}};
      vt[9]  = '{32'h12345678, 32'h10,       1'b0, 1'b0, {32'd8,        32'h01234567}};
      vt[10] = '{32'd0,        32'd5,        1'b1, 1'b1, 64'h0};
      vt[11] = '{32'd5,        32'd9,        1'b1, 1'b0, {32'd5,        32'd0}};
      vt[12] = '{32'h80000000, 32'd1,        1'b1, 1'b0, {32'h0,        32'h80000000}};

      // reset, with start held high: must not stall or launch
      rst = 1'b1;
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0;
      bus.start = 1'b1; bus.annul = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("reset_result", bus.result, 64'h0);
      check("reset_ready", 64'(bus.ready), 64'd0);
      check("reset_stall", 64'(bus.stall_req), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; bus.start = 1'b0;

      for (int v = 0; v < 13; v++) begin
         run_div($sformatf("vec%0d", v), vt[v].a, vt[v].b, vt[v].s, vt[v].noise, res);
         check($sformatf("vec%0d_result", v), res, vt[v].exp);
      end

      // result held across idle cycles
      prev = bus.result;
      repeat (3) @(negedge clk);
      #1;
      check("hold_result", bus.result, 64'h80000000);

      // annul during DIV_ON at cycle 10, then 9/3 starting at cycle 12
      prev = bus.result;
      rdy_seen = 0;
      @(negedge clk);
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.annul = (i == 10) ? 1'b1 : 1'b0;
         @(negedge clk); #1;
         if (bus.ready === 1'b1) rdy_seen++;
      end
      check("annul_on_stall", 64'(bus.stall_req), 64'd0);
      check("annul_on_no_ready", 64'(rdy_seen), 64'd0);
      check("annul_on_result", bus.result, prev);
      run_div("after_annul", 32'd9, 32'd3, 1'b0, 1'b0, res);
      check("after_annul_result", res, {32'd0, 32'd3});

      // annul during DIV_ZERO
      prev = bus.result;
      rdy_seen = 0;
      @(negedge clk);
      bus.a = 32'd55; bus.b = 32'd0; bus.start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.annul = (i == 1) ? 1'b1 : 1'b0;
         @(negedge clk); #1;
         if (bus.ready === 1'b1) rdy_seen++;
      end
      check("annul_zero_no_ready", 64'(rdy_seen), 64'd0);
      check("annul_zero_result", bus.result, prev);

      // annul and start together in IDLE: annul wins
      stall_seen = 0;
      rdy_seen = 0;
      @(negedge clk);
      bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1; bus.annul = 1'b1;
      #1;
      check("annul_start_stall", 64'(bus.stall_req), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0; bus.annul = 1'b0;
         @(negedge clk); #1;
         if (bus.stall_req === 1'b1) stall_seen++;
         if (bus.ready === 1'b1) rdy_seen++;
      end
      check("annul_start_no_launch", 64'(stall_seen + rdy_seen), 64'd0);

      // reset at cycle 20 of a division
      rdy_seen = 0;
      @(negedge clk);
      bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         rst = (i == 20) ? 1'b1 : 1'b0;
         @(negedge clk); #1;
         if (bus.ready === 1'b1) rdy_seen++;
      end
      check("rst_mid_result", bus.result, 64'h0);
      check("rst_mid_ready", 64'(bus.ready), 64'd0);
      check("rst_mid_stall", 64'(bus.stall_req), 64'd0);
      stall_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk); #1;
         if (bus.ready === 1'b1) rdy_seen++;
         if (bus.stall_req === 1'b1) stall_seen++;
      end
      check("rst_mid_no_ready", 64'(rdy_seen), 64'd0);
      check("rst_mid_idle", 64'(stall_seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
- REQ-001: The block SHALL use one clock; reset is synchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  synchronous active-high reset.
- REQ-004: a  input  32  dividend (rs value).
- REQ-005: b  input  32  divisor (rt value).
- REQ-006: signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- REQ-007: start  input  1  request a new division; sampled only in IDLE.
- REQ-008: annul  input  1  flush/exception cancel of the in-flight division.
- REQ-009: result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- REQ-010: ready  output  1  one-cycle pulse; result is valid and newly written in that cycle.
- REQ-011: stall_req  output  1  combinational pipeline stall request to the EX stage.

Function
- REQ-012: The state machine SHALL have four states: IDLE, DIV_ZERO, DIV_ON, DIV_END.
- REQ-013: IDLE + start + b!=0 SHALL latch operands (absolute values if signed_div, raw if not), the signs of a and b, and signed_div; next state DIV_ON with iteration counter = 0.
- REQ-014: IDLE + start + b==0 SHALL go to DIV_ZERO; DIV_ZERO SHALL go to DIV_END next cycle with result = 64'h0.
- REQ-015: DIV_ON SHALL run one restoring shift/subtract iteration per cycle (33-bit partial remainder, one quotient bit per cycle, MSB first) for exactly 32 cycles, then go to DIV_END.
- REQ-016: On entry to DIV_END, if signed_div: quotient SHALL be negated when sign(a)!=sign(b); remainder SHALL be negated when a was negative; remainder sign always follows dividend.
- REQ-017: DIV_END SHALL assert ready for exactly one cycle and go to IDLE unconditionally.
- REQ-018: Latency SHALL be fixed: start sampled at edge T -> ready high in cycle T+33 (b!=0) or T+2 (b==0).
- REQ-019: result SHALL be registered, written only on entry to DIV_END, and held until the next completed division.
- REQ-020: stall_req SHALL be (IDLE & start) | DIV_ZERO | DIV_ON; it SHALL be 0 in DIV_END and in IDLE without start.
- REQ-021: a, b and signed_div SHALL be ignored outside the IDLE start cycle; changes mid-operation SHALL not affect the result.
- REQ-022: start asserted while not IDLE SHALL be ignored; there is no queueing.
- REQ-023: annul in DIV_ON or DIV_ZERO SHALL force IDLE next cycle with no ready pulse and no change to result; annul in IDLE or DIV_END SHALL have no effect.
- REQ-024: annul and start together in IDLE SHALL give annul priority: no division starts and stall_req = 0.
- REQ-025: Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no exception or overflow flag.
- REQ-026: Unsigned operands SHALL use the full 32-bit range; 0xFFFFFFFF is never treated as negative.

Reset
- REQ-027: rst SHALL take priority over annul and start.
- REQ-028: rst SHALL force IDLE, counter = 0, result = 64'h0, ready = 0 and stall_req = 0 (stall_req low once rst is seen, start ignored).
- REQ-029: rst mid-operation SHALL abort the division with no ready pulse.

Verification
- REQ-030: Unsigned 100 / 7, start at T -> ready only at T+33, result = {32'd2, 32'd14}; stall_req high T..T+32 and low at T+33.
- REQ-031: Signed -7 / 2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7 / -2 -> {32'h00000001, 32'hFFFFFFFD}.
- REQ-032: Unsigned 0xFFFFFFFF / 1 -> {0, 32'hFFFFFFFF}; signed 0x80000000 / 0xFFFFFFFF -> {0, 32'h80000000}.
- REQ-033: b = 0, start at T -> ready at T+2, result = 64'h0, stall_req high at T and T+1 only.
- REQ-034: Annul at T+10 -> IDLE at T+11, no ready, result unchanged; a new start at T+12 with 9 / 3 -> ready at T+45, result {0, 3}.
- REQ-035: Assert rst at T+20 mid-division -> all outputs zero at T+21, no ready; operand changes during DIV_ON leave the result unchanged.
